// File: rtl/comparator.sv
// comparator: N-bit magnitude comparator, unsigned or two's-complement signed.
//
// The operands are split into NUM_LANES slices of VEC_W bits. Each slice is
// compared by its own lane instance, and the most significant slice that
// differs decides the ordering.
//
// Ports:
//   clk   - rising-edge clock for the registered copy o_q
//   rst_n - async active-low reset, clears o_q only
//   s     - 0 = unsigned compare, 1 = signed compare
//   a, b  - N-bit operands
//   o     - combinational flags {eq, neq, lt, lte, gt, gte}
//   o_q   - o registered on clk, 6'b0 while in reset

module comparator_lane #(
  parameter int VEC_W = 8
) (
  input  logic [VEC_W-1:0] a,
  input  logic [VEC_W-1:0] b,
  output logic             eq,
  output logic             gt
);
  assign eq = (a == b);
  assign gt = (a > b);
endmodule

module comparator #(
  parameter int N     = 32,
  parameter int VEC_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [5:0]   o,
  output logic [5:0]   o_q
);
  localparam int NUM_LANES = (N + VEC_W - 1) / VEC_W;
  localparam int PAD_W     = NUM_LANES * VEC_W;

  logic [N-1:0]                    a_m, b_m;
  logic [PAD_W-1:0]                a_p, b_p;
  logic [NUM_LANES-1:0][VEC_W-1:0] a_l, b_l;
  logic [NUM_LANES-1:0]            l_eq, l_gt;
  logic                            eq, gt, lt;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  always_comb begin
    a_m        = a;
    b_m        = b;
    a_m[N-1]   = a[N-1] ^ s;
    b_m[N-1]   = b[N-1] ^ s;
  end

  // Zero-extend both operands to a whole number of lanes; the padding bits
  // are equal in both, so they never influence the result.
  always_comb begin
    a_p        = '0;
    b_p        = '0;
    a_p[N-1:0] = a_m;
    b_p[N-1:0] = b_m;
  end

  assign a_l = a_p;
  assign b_l = b_p;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    comparator_lane #(.VEC_W(VEC_W)) u_lane (
      .a  (a_l[i]),
      .b  (b_l[i]),
      .eq (l_eq[i]),
      .gt (l_gt[i])
    );
  end

  // Scan from the least significant lane upward so the highest differing
  // lane is the last to write gt.
  always_comb begin
    gt = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!l_eq[i]) gt = l_gt[i];
    end
  end

  assign eq = &l_eq;
  assign lt = ~eq & ~gt;
  assign o  = {eq, ~eq, lt, lt | eq, gt, gt | eq};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_q <= '0;
    else        o_q <= o;
  end
endmodule

// File: tb/tb_comparator.sv
module tb_comparator;
  localparam logic [5:0] LT = 6'b011100;
  localparam logic [5:0] EQ = 6'b100101;
  localparam logic [5:0] GT = 6'b010011;

  typedef struct {
    logic [5:0] e32;
    logic [5:0] e8;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s;
  logic [31:0] a, b;
  logic [7:0]  a8, b8;
  logic [5:0]  o, o_q, o8, o8_q;

  int checks = 0;
  int errors = 0;
  exp_t q[$];
  exp_t mx;

  always #5 clk = ~clk;

  comparator #(.N(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .s(s), .a(a), .b(b), .o(o), .o_q(o_q)
  );

  comparator #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .s(s), .a(a8), .b(b8), .o(o8), .o_q(o8_q)
  );

  function automatic logic [5:0] enc(input logic lt, input logic gt);
    logic eq;
    eq = ~lt & ~gt;
    return {eq, ~eq, lt, lt | eq, gt, gt | eq};
  endfunction

  function automatic logic [5:0] cmp32(input logic si, input logic [31:0] x, input logic [31:0] y);
    if (si) return enc($signed(x) < $signed(y), $signed(x) > $signed(y));
    return enc(x < y, x > y);
  endfunction

  function automatic logic [5:0] cmp8(input logic si, input logic [7:0] x, input logic [7:0] y);
    if (si) return enc($signed(x) < $signed(y), $signed(x) > $signed(y));
    return enc(x < y, x > y);
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (s=%b a=%h b=%h)", name, act, exp, s, a, b);
    end
  endtask

  // Drive one vector per cycle; o is checked immediately, o_q via the queue.
  task automatic apply(input logic si, input logic [31:0] ai, input logic [31:0] bi,
                       input logic [5:0] e);
    exp_t x;
    logic [7:0] a_lo, b_lo;
    @(negedge clk);
    a_lo = ai[7:0];
    b_lo = bi[7:0];
    s = si; a = ai; b = bi; a8 = a_lo; b8 = b_lo;
    #1;
    x.e32 = e;
    x.e8  = cmp8(si, a_lo, b_lo);
    check("o32", o, x.e32);
    check("o8", o8, x.e8);
    q.push_back(x);
  endtask

  // Monitor: after each rising edge, o_q must hold the previous cycle's o.
  always @(posedge clk) begin
    #1;
    if (rst_n && q.size() > 0) begin
      mx = q.pop_front();
      check("o_q32", o_q, mx.e32);
      check("o_q8", o8_q, mx.e8);
    end
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    rst_n = 1'b0; s = 1'b0; a = 32'd0; b = 32'd1; a8 = 8'd0; b8 = 8'd1;

    // Reset holds o_q at zero across edges while o tracks inputs.
    repeat (3) @(negedge clk);
    check("rst_o_q32", o_q, 6'b000000);
    check("rst_o_q8", o8_q, 6'b000000);
    check("rst_o32", o, LT);
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b0, 32'd0, 32'd1, LT);

    // Small values in both modes.
    for (int m = 0; m < 2; m++) begin
      apply(m[0], 32'd0, 32'd1, LT);
      apply(m[0], 32'd1, 32'd1, EQ);
      apply(m[0], 32'd1, 32'd0, GT);
    end

    // Sign boundary.
    apply(1'b0, 32'hFFFFFFFF, 32'h0, GT);
    apply(1'b1, 32'hFFFFFFFF, 32'h0, LT);
    apply(1'b0, 32'h7FFFFFFF, 32'h80000000, LT);
    apply(1'b1, 32'h7FFFFFFF, 32'h80000000, GT);
    apply(1'b0, 32'h0, 32'hFFFFFFFF, LT);
    apply(1'b1, 32'h0, 32'hFFFFFFFF, GT);

    // Both negative / equal.
    apply(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, EQ);
    apply(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, EQ);
    apply(1'b0, 32'hFFFFFFFE, 32'hFFFFFFFF, LT);
    apply(1'b1, 32'hFFFFFFFE, 32'hFFFFFFFF, LT);
    apply(1'b0, 32'hFFFFFFFE, 32'h0, GT);
    apply(1'b1, 32'hFFFFFFFE, 32'h0, LT);
    // Differences confined to a low or high lane.
    apply(1'b0, 32'h12345678, 32'h12345679, LT);
    apply(1'b1, 32'h80000001, 32'h80000000, GT);
    apply(1'b0, 32'h01000000, 32'h00FFFFFF, GT);

    // Async reset between edges clears o_q at once; o keeps tracking.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    q.delete();
    check("async_o_q32", o_q, 6'b000000);
    check("async_o_q8", o8_q, 6'b000000);
    a = 32'd5; b = 32'd3; s = 1'b0;
    #1;
    check("rst_track_o32", o, GT);
    @(posedge clk);
    #1;
    check("rst_hold_o_q32", o_q, 6'b000000);
    @(negedge clk);
    rst_n = 1'b1;

    // Random vectors, both modes and both widths.
    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      rb = (i % 8 == 0) ? ra : $urandom;
      if (i % 16 == 3) rb = {ra[31:8], rb[7:0]};
      rs = $urandom_range(0, 1);
      apply(rs, ra, rb, cmp32(rs, ra, rb));
    end

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
